// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT2232H synchronous-245 interface blocks:
// bus strobe polarity, byte width and the receive controller state encoding.
package ftdi_pkg;

    // Byte width of the FT2232H data bus.
    localparam int BYTE_W = 8;

    // RD#, OE#, RXF# and TXE# are all active-low on the FT2232H.
    localparam logic FTDI_ACTIVE = 1'b0;

    // Receive controller states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OE_SETUP = 2'd1,
        READ     = 2'd2
    } rx_state_t;

endpackage : ftdi_pkg

// File: rtl/ftdi_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO. The head byte is visible on
// dout whenever level is non-zero; dout reads as zero while the FIFO is empty.
module ftdi_rx_fifo
    import ftdi_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK_FTDI,
    input  logic              RST_N,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic [ADDR_W:0]   level
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Write the incoming byte at the tail.
    // NOTE: the storage array has no reset; only the pointers and level are
    // cleared, which is enough to discard the contents and keeps it RAM-friendly.
    always_ff @(posedge CLK_FTDI) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Advance pointers (wrapping mod DEPTH) and track occupancy; a push and a
    // pop on the same edge leave the level unchanged.
    always_ff @(posedge CLK_FTDI or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Head of buffer, forced to zero when empty so stale storage never shows.
    assign dout = (level != '0) ? mem[rd_ptr] : '0;

endmodule : ftdi_rx_fifo

// File: rtl/ftdi_rx_reader.sv
// FT2232H synchronous-245 receive path. Watches RXF#, sequences OE# then RD#
// to pull host bytes off the bus, buffers them in a FWFT FIFO and presents
// them on a valid/ready stream. Never drives the data bus; the top level
// releases its drivers whenever OUT_EN is low.
module ftdi_rx_reader
    import ftdi_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK_FTDI,
    input  logic              RST_N,
    input  logic              RX_EMPTY,
    input  logic [BYTE_W-1:0] DATA_IN,
    output logic              READ_N,
    output logic              OUT_EN,
    output logic [BYTE_W-1:0] M_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [ADDR_W:0]   LEVEL,
    output logic [CNT_W-1:0]  RX_BYTE_CNT
);

    rx_state_t         state;
    logic              host_ready;
    logic              cap;
    logic              pop;
    logic              space;
    logic [ADDR_W+1:0] next_level;

    // A byte is taken on every edge where the host has data and RD# is low.
    assign host_ready = (RX_EMPTY == FTDI_ACTIVE);
    assign cap        = host_ready && (READ_N == FTDI_ACTIVE);
    assign pop        = M_VALID && M_READY;

    // Room is judged on the occupancy after this edge, so the byte captured
    // on the exit edge is already accounted for and the FIFO cannot overflow.
    assign next_level = {1'b0, LEVEL} + (ADDR_W+2)'(cap) - (ADDR_W+2)'(pop);
    assign space      = next_level < (ADDR_W+2)'(DEPTH);

    assign M_VALID = (LEVEL != '0);

    ftdi_rx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .CLK_FTDI (CLK_FTDI),
        .RST_N    (RST_N),
        .push     (cap),
        .din      (DATA_IN),
        .pop      (pop),
        .dout     (M_DATA),
        .level    (LEVEL)
    );

    // Strobe sequencer: OE# leads RD# by one turnaround cycle on entry, and
    // both are released together on the edge that leaves READ.
    // NOTE: state and strobes use non-blocking assignments so every branch
    // sees the pre-edge values and the outputs stay glitch-free registers.
    always_ff @(posedge CLK_FTDI or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            READ_N <= ~FTDI_ACTIVE;
            OUT_EN <= ~FTDI_ACTIVE;
        end else begin
            case (state)
                IDLE: begin
                    if (host_ready && space) begin
                        state  <= OE_SETUP;
                        OUT_EN <= FTDI_ACTIVE;
                    end
                end
                OE_SETUP: begin
                    if (host_ready && space) begin
                        state  <= READ;
                        READ_N <= FTDI_ACTIVE;
                    end else begin
                        state  <= IDLE;
                        OUT_EN <= ~FTDI_ACTIVE;
                    end
                end
                READ: begin
                    if (!(host_ready && space)) begin
                        state  <= IDLE;
                        READ_N <= ~FTDI_ACTIVE;
                        OUT_EN <= ~FTDI_ACTIVE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    READ_N <= ~FTDI_ACTIVE;
                    OUT_EN <= ~FTDI_ACTIVE;
                end
            endcase
        end
    end

    // Running count of captured bytes, wrapping at 2^CNT_W.
    always_ff @(posedge CLK_FTDI or negedge RST_N) begin
        if (!RST_N) begin
            RX_BYTE_CNT <= '0;
        end else if (cap) begin
            RX_BYTE_CNT <= RX_BYTE_CNT + CNT_W'(1);
        end
    end

endmodule : ftdi_rx_reader

// File: tb/tb_ftdi_rx_reader.sv
// Self-checking bench for ftdi_rx_reader: a directed vector table for reset,
// strobe sequencing, short capture, pops and turnaround abort, followed by
// hand-written multi-cycle sequences driven by a simple FT2232H host model.
module tb_ftdi_rx_reader;
    import ftdi_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic              CLK_FTDI = 1'b0;
    logic              RST_N;
    logic              RX_EMPTY;
    logic [7:0]        DATA_IN;
    logic              READ_N;
    logic              OUT_EN;
    logic [7:0]        M_DATA;
    logic              M_VALID;
    logic              M_READY;
    logic [ADDR_W:0]   LEVEL;
    logic [CNT_W-1:0]  RX_BYTE_CNT;

    int n_checks = 0;
    int n_pass   = 0;

    // Host model: bytes waiting in the FT2232H, advanced on each capture.
    logic [7:0] host_mem [64];
    int         host_len;
    int         host_idx;
    bit         host_on;

    // Bytes accepted by the consumer, in order.
    logic [7:0] rx_q [$];

    always #8 CLK_FTDI = ~CLK_FTDI;

    ftdi_rx_reader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK_FTDI    (CLK_FTDI),
        .RST_N       (RST_N),
        .RX_EMPTY    (RX_EMPTY),
        .DATA_IN     (DATA_IN),
        .READ_N      (READ_N),
        .OUT_EN      (OUT_EN),
        .M_DATA      (M_DATA),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .LEVEL       (LEVEL),
        .RX_BYTE_CNT (RX_BYTE_CNT)
    );

    typedef struct {
        logic        rst_n;
        logic        rx_empty;
        logic        m_ready;
        logic [7:0]  data_in;
        logic        exp_read_n;
        logic        exp_out_en;
        logic        exp_m_valid;
        logic [7:0]  exp_m_data;
        logic [4:0]  exp_level;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive_host();
        if (host_on) begin
            RX_EMPTY = (host_idx >= host_len);
            DATA_IN  = (host_idx < host_len) ? host_mem[host_idx] : 8'h00;
        end
    endtask

    // One clock cycle, entered and left just after a falling edge. Captures
    // and pops are decided by the values that are stable at the rising edge.
    task automatic step();
        logic will_cap;
        logic will_pop;
        will_cap = host_on && RST_N && !RX_EMPTY && !READ_N;
        will_pop = RST_N && M_VALID && M_READY;
        if (will_pop) rx_q.push_back(M_DATA);
        @(posedge CLK_FTDI);
        @(negedge CLK_FTDI);
        if (will_cap) host_idx++;
        drive_host();
    endtask

    task automatic do_reset();
        host_on  = 1'b0;
        RX_EMPTY = 1'b1;
        M_READY  = 1'b0;
        DATA_IN  = 8'h00;
        RST_N    = 1'b0;
        @(posedge CLK_FTDI);
        @(negedge CLK_FTDI);
        RST_N    = 1'b1;
        host_idx = 0;
        host_len = 0;
        rx_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int errs;

        //          rst rxe rdy din    | rd_n oe  vld data   lvl    cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 5'd1, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 8'h33, 5'd2, 16'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 8'h33, 5'd2, 16'd2};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 1'b1, 8'h33, 5'd2, 16'd2};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h44, 5'd1, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 16'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 16'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 16'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'hBB, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 16'd2};

        host_on  = 1'b0;
        host_idx = 0;
        host_len = 0;
        RST_N    = 1'b0;
        RX_EMPTY = 1'b0;
        M_READY  = 1'b0;
        DATA_IN  = 8'h00;
        @(negedge CLK_FTDI);

        // Reset held with data pending, release, strobe sequencing, short
        // capture, pops, then a one-cycle RXF# pulse that aborts in OE_SETUP.
        for (int i = 0; i < 12; i++) begin
            RST_N    = vecs[i].rst_n;
            RX_EMPTY = vecs[i].rx_empty;
            M_READY  = vecs[i].m_ready;
            DATA_IN  = vecs[i].data_in;
            @(posedge CLK_FTDI);
            @(negedge CLK_FTDI);
            check($sformatf("vec%0d_read_n", i), READ_N, vecs[i].exp_read_n);
            check($sformatf("vec%0d_out_en", i), OUT_EN, vecs[i].exp_out_en);
            check($sformatf("vec%0d_m_valid", i), M_VALID, vecs[i].exp_m_valid);
            check($sformatf("vec%0d_m_data", i), M_DATA, vecs[i].exp_m_data);
            check($sformatf("vec%0d_level", i), LEVEL, vecs[i].exp_level);
            check($sformatf("vec%0d_cnt", i), RX_BYTE_CNT, vecs[i].exp_cnt);
        end

        // Burst of five bytes with the consumer always ready.
        do_reset();
        for (int i = 0; i < 5; i++) host_mem[i] = 8'(8'hA0 + i);
        host_len = 5;
        M_READY  = 1'b1;
        host_on  = 1'b1;
        drive_host();
        t = 0;
        while (host_idx < host_len && t < 50) begin
            step();
            t++;
        end
        check("burst_bytes_taken", host_idx, 5);
        check("burst_read_n_on_last", READ_N, 1'b0);
        step();
        check("burst_read_n_exit", READ_N, 1'b1);
        check("burst_out_en_exit", OUT_EN, 1'b1);
        repeat (5) step();
        check("burst_rx_count", rx_q.size(), 5);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== 8'(8'hA0 + i)) errs++;
        end
        check("burst_order", errs, 0);
        check("burst_byte_cnt", RX_BYTE_CNT, 5);
        check("burst_level_drained", LEVEL, 0);

        // Backpressure: 40 bytes offered, consumer stalled, then released.
        do_reset();
        for (int i = 0; i < 40; i++) host_mem[i] = 8'(8'h40 + i);
        host_len = 40;
        M_READY  = 1'b0;
        host_on  = 1'b1;
        drive_host();
        repeat (60) step();
        check("bp_level_full", LEVEL, 16);
        check("bp_read_n_full", READ_N, 1'b1);
        check("bp_out_en_full", OUT_EN, 1'b1);
        check("bp_bytes_taken", host_idx, 16);
        check("bp_cnt_full", RX_BYTE_CNT, 16);
        check("bp_head", M_DATA, 8'h40);
        M_READY = 1'b1;
        t = 0;
        while (rx_q.size() < 40 && t < 300) begin
            step();
            t++;
        end
        check("bp_rx_count", rx_q.size(), 40);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== 8'(8'h40 + i)) errs++;
        end
        check("bp_order", errs, 0);
        check("bp_byte_cnt", RX_BYTE_CNT, 40);

        // Simultaneous push and pop holding the level at 8.
        do_reset();
        for (int i = 0; i < 30; i++) host_mem[i] = 8'(8'h80 + i);
        host_len = 30;
        M_READY  = 1'b0;
        host_on  = 1'b1;
        drive_host();
        t = 0;
        while (LEVEL != 5'd8 && t < 30) begin
            step();
            t++;
        end
        check("pp_reach_level8", LEVEL, 8);
        M_READY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("pp_level_c%0d", k), LEVEL, 8);
            check($sformatf("pp_read_n_c%0d", k), READ_N, 1'b0);
        end
        t = 0;
        while (rx_q.size() < 30 && t < 200) begin
            step();
            t++;
        end
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== 8'(8'h80 + i)) errs++;
        end
        check("pp_order", errs, 0);

        // Reset in the middle of a six-byte burst.
        do_reset();
        for (int i = 0; i < 6; i++) host_mem[i] = 8'(8'hC0 + i);
        host_len = 6;
        M_READY  = 1'b0;
        host_on  = 1'b1;
        drive_host();
        t = 0;
        while (host_idx < 3 && t < 20) begin
            step();
            t++;
        end
        check("mr_bytes_before", host_idx, 3);
        check("mr_read_n_before", READ_N, 1'b0);
        RST_N = 1'b0;
        #1;
        check("mr_read_n_async", READ_N, 1'b1);
        check("mr_out_en_async", OUT_EN, 1'b1);
        check("mr_level_async", LEVEL, 0);
        check("mr_cnt_async", RX_BYTE_CNT, 0);
        check("mr_valid_async", M_VALID, 1'b0);
        @(negedge CLK_FTDI);
        rx_q.delete();
        repeat (2) step();
        RST_N   = 1'b1;
        M_READY = 1'b1;
        t = 0;
        while (rx_q.size() < 3 && t < 40) begin
            step();
            t++;
        end
        check("mr_rx_count", rx_q.size(), 3);
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== 8'(8'hC3 + i)) errs++;
        end
        check("mr_resume_order", errs, 0);
        check("mr_byte_cnt", RX_BYTE_CNT, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ftdi_rx_reader
